// File: rtl/hexkey_scanner.sv
// hexkey_scanner: keypad matrix scanner, debounce, key encode, valid/ack hand-off.
// Define HEXKEY_SCANNER_REPEAT_EN to add auto-repeat while a key stays held.
module hexkey_scanner #(
   parameter int N_ROWS       = 4,
   parameter int N_COLS       = 4,
   parameter int SCAN_DIV     = 10000,
   parameter int DEBOUNCE_CNT = 50000,
`ifdef HEXKEY_SCANNER_REPEAT_EN
   parameter int REPEAT_DLY   = 5000000,
   parameter int REPEAT_PER   = 1000000,
`endif
   localparam int CODE_W      = $clog2(N_ROWS*N_COLS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_ROWS-1:0] row_in,
   output logic [N_COLS-1:0] col_drive,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   input  logic              key_ack,
   output logic              key_held,
   output logic              overrun
);

   localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
   localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
   localparam int DW_W  = $clog2(SCAN_DIV + 1);
   localparam int DB_W  = $clog2(DEBOUNCE_CNT + 1);

   localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(SCAN_DIV - 1);
   localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CNT);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CNT - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);

`ifdef HEXKEY_SCANNER_REPEAT_EN
   localparam int RP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int RP_W   = $clog2(RP_MAX + 1);
   localparam logic [RP_W-1:0] RP_DLY_LAST = RP_W'(REPEAT_DLY - 1);
   localparam logic [RP_W-1:0] RP_PER_LAST = RP_W'(REPEAT_PER - 1);
`endif

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD
   } state_t;

   state_t            state_q, state_d;
   logic [DW_W-1:0]   dwell_q, dwell_d;
   logic [DB_W-1:0]   cnt_q, cnt_d;
   logic [COL_W-1:0]  col_q, col_d, col_nxt;
   logic [ROW_W-1:0]  row_q, row_d, low_row;
   logic [N_ROWS-1:0] meta_q, rs_q;
   logic [CODE_W-1:0] code_q, code_d, code_cur;
   logic              valid_q, valid_d;
   logic              held_q, held_d;
   logic              ovr_q, ovr_d;
   logic              issue, row_hit;

`ifdef HEXKEY_SCANNER_REPEAT_EN
   logic [RP_W-1:0]   rep_cnt_q, rep_cnt_d;
   logic              rep_first_q, rep_first_d;
`endif

   assign row_hit  = rs_q[row_q];
   assign col_nxt  = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
   assign code_cur = CODE_W'(row_q) * CODE_W'(N_COLS) + CODE_W'(col_q);

   always_comb begin
      col_drive        = '0;
      col_drive[col_q] = 1'b1;
   end

   // Lowest asserted row wins when several rows close on one column.
   always_comb begin
      low_row = '0;
      for (int i = N_ROWS - 1; i >= 0; i--) begin
         if (rs_q[i]) low_row = ROW_W'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q;
      cnt_d   = cnt_q;
      col_d   = col_q;
      row_d   = row_q;
      held_d  = held_q;
      issue   = 1'b0;
`ifdef HEXKEY_SCANNER_REPEAT_EN
      rep_cnt_d   = rep_cnt_q;
      rep_first_d = rep_first_q;
`endif
      unique case (state_q)
         SCAN: begin
            if (dwell_q == DW_LAST) begin
               dwell_d = '0;
               if (|rs_q) begin
                  row_d   = low_row;
                  cnt_d   = '0;
                  state_d = DEBOUNCE;
               end else begin
                  col_d = col_nxt;
               end
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (cnt_q == DB_MAX) begin
               issue   = 1'b1;
               held_d  = 1'b1;
               cnt_d   = '0;
               state_d = HELD;
`ifdef HEXKEY_SCANNER_REPEAT_EN
               rep_cnt_d   = '0;
               rep_first_d = 1'b1;
`endif
            end else if (row_hit) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               cnt_d   = '0;
               col_d   = col_nxt;
               state_d = SCAN;
            end
         end
         HELD: begin
            if (!row_hit && cnt_q == DB_LAST) begin
               held_d  = 1'b0;
               cnt_d   = '0;
               col_d   = col_nxt;
               state_d = SCAN;
`ifdef HEXKEY_SCANNER_REPEAT_EN
               rep_cnt_d   = '0;
               rep_first_d = 1'b1;
`endif
            end else begin
               cnt_d = row_hit ? '0 : cnt_q + 1'b1;
`ifdef HEXKEY_SCANNER_REPEAT_EN
               if (rep_cnt_q == (rep_first_q ? RP_DLY_LAST : RP_PER_LAST)) begin
                  issue       = 1'b1;
                  rep_cnt_d   = '0;
                  rep_first_d = 1'b0;
               end else begin
                  rep_cnt_d = rep_cnt_q + 1'b1;
               end
`endif
            end
         end
         default: state_d = SCAN;
      endcase
   end

   // An ack in the issue cycle retires the old code, so no overrun.
   always_comb begin
      code_d  = code_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (valid_q && key_ack) valid_d = 1'b0;
      if (issue) begin
         code_d  = code_cur;
         valid_d = 1'b1;
         if (valid_q && !key_ack) ovr_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SCAN;
         dwell_q <= '0;
         cnt_q   <= '0;
         col_q   <= '0;
         row_q   <= '0;
         meta_q  <= '0;
         rs_q    <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         held_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dwell_q <= dwell_d;
         cnt_q   <= cnt_d;
         col_q   <= col_d;
         row_q   <= row_d;
         meta_q  <= row_in;
         rs_q    <= meta_q;
         code_q  <= code_d;
         valid_q <= valid_d;
         held_q  <= held_d;
         ovr_q   <= ovr_d;
      end
   end

`ifdef HEXKEY_SCANNER_REPEAT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         rep_cnt_q   <= '0;
         rep_first_q <= 1'b1;
      end else begin
         rep_cnt_q   <= rep_cnt_d;
         rep_first_q <= rep_first_d;
      end
   end
`endif

   assign key_code  = code_q;
   assign key_valid = valid_q;
   assign key_held  = held_q;
   assign overrun   = ovr_q;

endmodule
